// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: state encoding and start/halt address table shared by prog_sequencer.
package prog_seq_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_e;
    localparam int NPROG_DEF = 3;
    localparam int P0_START = 0;
    localparam int P0_HALT = 195;
    localparam int P1_START = 196;
    localparam int P1_HALT = 400;
    localparam int P2_START = 401;
    localparam int P2_HALT = 640;
endpackage

// File: rtl/prog_seq_table.sv
// prog_table: combinational program index to {start, halt} address lookup.
module prog_table
    import prog_seq_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [1:0]   idx,
    output logic [D-1:0] start_addr,
    output logic [D-1:0] halt_addr
);
    // Indices beyond the table fall back to program 0; the FSM never launches them.
    always_comb begin
        start_addr = idx == 2'd1 ? D'(P1_START) : idx == 2'd2 ? D'(P2_START) : D'(P0_START);
        halt_addr  = idx == 2'd1 ? D'(P1_HALT)  : idx == 2'd2 ? D'(P2_HALT)  : D'(P0_HALT);
    end
endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: launches a table-selected program on the core, watches its PC for
// the halt address and reports completion, timeout or abort with a RUN-cycle count.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int D     = 12,
    parameter int NPROG = NPROG_DEF,
    parameter int CW    = 16,
    parameter int TMAX  = 2**CW - 1
) (
    input  logic          clk,
    input  logic          start,
    input  logic          req,
    input  logic [1:0]    prog_sel,
    input  logic          abort,
    input  logic [D-1:0]  prog_ctr_out,
    output logic          core_start,
    output logic [D-1:0]  start_address,
    output logic          busy,
    output logic          ack,
    output logic          timeout,
    output logic          aborted,
    output logic          err,
    output logic [CW-1:0] cycles
);
    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [D-1:0]  addr_q, addr_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d, aborted_q, aborted_d, err_q, err_d;
    logic          core_start_q, core_start_d, busy_q, busy_d, ack_q, ack_d;
    logic [D-1:0]  tab_start, tab_halt;
    logic          sel_ok, at_limit;

    // In IDLE the table looks up the incoming select so LAUNCH already shows its start address.
    prog_table #(.D(D)) u_table (
        .idx        (state_q == IDLE ? prog_sel : sel_q),
        .start_addr (tab_start),
        .halt_addr  (tab_halt)
    );

    always_comb begin
        sel_ok    = int'(prog_sel) < NPROG;
        at_limit  = cycles_q + CW'(1) == CW'(TMAX);
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && sel_ok) begin
                    state_d   = LAUNCH;
                    sel_d     = prog_sel;
                    addr_d    = tab_start;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                end
                err_d = req && !sel_ok;
            end
            LAUNCH: begin
                state_d   = abort ? DONE : RUN;
                aborted_d = abort;
            end
            RUN: begin
                cycles_d  = cycles_q + CW'(1);
                state_d   = abort || prog_ctr_out == tab_halt || at_limit ? DONE : RUN;
                aborted_d = abort;
                timeout_d = !abort && prog_ctr_out != tab_halt && at_limit;
            end
            DONE: state_d = IDLE;
        endcase
        core_start_d = state_d != RUN;
        busy_d       = state_d != IDLE;
        ack_d        = state_d == DONE;
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            addr_q       <= D'(P0_START);
            cycles_q     <= '0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign core_start    = core_start_q;
    assign start_address = addr_q;
    assign busy          = busy_q;
    assign ack           = ack_q;
    assign timeout       = timeout_q;
    assign aborted       = aborted_q;
    assign err           = err_q;
    assign cycles        = cycles_q;
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

- Run controller for the 9-bit single-cycle core. It accepts a program-launch request and parks or releases the core through its `start` input.
- It drives the core's `start_address`, watches `prog_ctr_out` for the program's halt address, and counts execution cycles.
- It reports completion, timeout or abort back to the testbench or host.
- It sits beside `top_level` and replaces that module's fixed `done` comparison with per-program start/halt addresses.

## Interface
Parameters:
- `D`, 12, program counter width; must match the core.
- `NPROG`, 3, number of programs in the table.
- `CW`, 16, cycle counter width.
- `TMAX`, 2**CW-1, RUN-cycle limit before timeout; valid range 1..2**CW-1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `start`  in  1  asynchronous, active-high reset.
- `req`  in  1  launch request; sampled only in IDLE.
- `prog_sel`  in  2  program index; sampled together with `req`.
- `abort`  in  1  cancel the current run; honoured in LAUNCH and RUN.
- `prog_ctr_out`  in  D  core PC.
- `core_start`  out  1  drives the core's `start`; 1 parks the PC at `start_address`.
- `start_address`  out  D  drives the core's start address.
- `busy`  out  1  high in LAUNCH, RUN and DONE.
- `ack`  out  1  one-cycle completion pulse, asserted in DONE.
- `timeout`  out  1  held from DONE until the next accepted `req`.
- `aborted`  out  1  held from DONE until the next accepted `req`.
- `err`  out  1  one-cycle pulse when `req` carries `prog_sel` >= `NPROG`.
- `cycles`  out  CW  RUN-cycle count of the last run; held until the next accepted `req`.

## Operation
States are IDLE, LAUNCH, RUN and DONE. Reset enters IDLE.

Reset values:
- `core_start` = 1
- `start_address` = start address of program 0
- all flags = 0
- `cycles` = 0

IDLE:
- `core_start` = 1.
- `req` with a valid `prog_sel`: latch the index; clear `cycles`, `timeout` and `aborted`; go to LAUNCH.
- `req` with an invalid `prog_sel`: pulse `err` next cycle; stay in IDLE; no other output changes.

LAUNCH (exactly one cycle):
- `core_start` = 1, `start_address` = start of the selected program. The core loads its PC at the end of this cycle.
- Next state is RUN, or DONE with `aborted` set if `abort` = 1.

RUN:
- `core_start` = 0, `cycles` increments by 1 every cycle.
- Exit conditions are evaluated each cycle, in priority order:
  1. `abort` = 1: go to DONE, set `aborted`.
  2. `prog_ctr_out` == halt address: go to DONE.
  3. `cycles` + 1 == `TMAX`: go to DONE, set `timeout`.
- `cycles` counts the exiting cycle, so the final value equals the number of RUN cycles.
- A halt match on the same cycle as the timeout limit counts as a normal completion: `timeout` stays 0.

DONE (exactly one cycle):
- `ack` = 1, `core_start` = 1.
- Next state is IDLE.

Other rules:
- `req` outside IDLE is ignored; there is no queueing.
- `abort` outside LAUNCH and RUN is ignored.
- Asserting `start` in any state returns to IDLE with reset values within the same cycle. No `ack` is produced.
- `start_address` keeps the last selected program's value through RUN, DONE and IDLE.

## Timing
- Launch sequence: `req` sampled high at edge 0 → LAUNCH during cycle 1 → RUN from cycle 2, with `prog_ctr_out` equal to the start address.
- Halt at the start address itself: match in the first RUN cycle, `cycles` = 1, `ack` in cycle 3.
- General case: `ack` arrives 3 + N − 1 cycles after the `req` edge, where N is the RUN-cycle count.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The halt comparison uses the current cycle's `prog_ctr_out`.

## Structure
Package `prog_seq_pkg` holds:
- The state enum: IDLE, LAUNCH, RUN, DONE.
- The start/halt address constants:
  - program 0: 0 / 195
  - program 1: 196 / 400
  - program 2: 401 / 640
- The `NPROG` default.

Sub-module `prog_table`:
- Combinational lookup: index → {start, halt}, reading the package constants.
- Out-of-range indices return program 0's addresses. The FSM never launches them.

## Test plan
- Bench parameters: `TMAX` = 8, and a halt address override that drives `prog_ctr_out` from a bench counter.
- Normal run: `req`, `prog_sel` = 1; `prog_ctr_out` reaches 400 in the 5th RUN cycle → `start_address` = 196 in LAUNCH, `cycles` = 5, `ack` once, `timeout` = 0, `busy` low after DONE.
- Timeout: `prog_sel` = 0, PC never reaches 195 → DONE after 8 RUN cycles, `cycles` = 8, `timeout` = 1.
- Halt on the limit cycle: halt match in the 8th RUN cycle → `timeout` = 0, `cycles` = 8.
- Invalid select: `req`, `prog_sel` = 3 → `err` pulses once, state stays IDLE, `core_start` stays 1.
- Abort priority: assert `abort` and a halt match in the same RUN cycle → `aborted` = 1, `ack` = 1.
- Reset and ignored requests: assert `start` mid-RUN → next cycle IDLE, `cycles` = 0, `core_start` = 1, no `ack`. A `req` issued during RUN is ignored.
